reg_file_mp: RTL and testbench

Parametrised multi-port integer register file, the next generation of the single-write, dual-read reg_file in the core datapath.
- Adds configurable read/write port counts and optional write-to-read bypass.
- Adds a per-register busy scoreboard for in-flight results.
- Adds synchronous clear of all registers on reset.
- Sits between decode (reads, allocation) and writeback (writes) in the pipelined core.

---
 rtl/reg_file_mp_pkg.sv | 21 ++
 rtl/reg_file_mp_if.sv | 32 +++
 rtl/reg_file_mp_wr_arb.sv | 29 ++
 rtl/reg_file_mp.sv | 122 ++++++++++++
 tb/tb_reg_file_mp.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/reg_file_mp_pkg.sv
// Shared defaults and packed-field helper for the multi-port register file.
package reg_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int AW_DEF    = $clog2(NREGS_DEF);

    // Widest packed port bus the field helper accepts; callers zero-extend into it.
    localparam int PACK_MAX  = 2048;

    function automatic logic [PACK_MAX-1:0] pack_field(
        input logic [PACK_MAX-1:0] vec,
        input int unsigned         idx,
        input int unsigned         w
    );
        logic [PACK_MAX-1:0] mask;
        mask = (PACK_MAX'(1) << w) - PACK_MAX'(1);
        return (vec >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Decode/writeback side bus of the multi-port register file.
interface reg_file_mp_if
    import reg_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int NREGS = NREGS_DEF,
    parameter int NRD   = 2,
    parameter int NWR   = 2
);
    localparam int AW = $clog2(NREGS);

    logic [NRD*AW-1:0]   rs_addr;
    logic [NRD*XLEN-1:0] rs_data;
    logic [NRD-1:0]      rs_busy;
    logic [NWR-1:0]      reg_write;
    logic [NWR*AW-1:0]   rd_addr;
    logic [NWR*XLEN-1:0] rd_data;
    logic                alloc_valid;
    logic [AW-1:0]       alloc_addr;
    logic                any_busy;

    modport master (
        output rs_addr, reg_write, rd_addr, rd_data, alloc_valid, alloc_addr,
        input  rs_data, rs_busy, any_busy
    );

    modport slave (
        input  rs_addr, reg_write, rd_addr, rd_data, alloc_valid, alloc_addr,
        output rs_data, rs_busy, any_busy
    );

endinterface

// File: rtl/reg_file_mp_wr_arb.sv
// Write-port arbiter: finds whether any enabled write port targets an address
// and which port wins (highest index).
module rf_wr_arb
    import reg_pkg::*;
#(
    parameter int NWR = 2,
    parameter int AW  = 5,
    parameter int IW  = 1
) (
    input  logic [NWR-1:0]    we,
    input  logic [NWR*AW-1:0] waddr,
    input  logic [AW-1:0]     target,
    output logic              hit,
    output logic [IW-1:0]     idx
);

    // Ascending scan so the last match, i.e. the highest port, is kept.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        for (int j = 0; j < NWR; j++) begin
            if (we[j] && (AW'(pack_field(PACK_MAX'(waddr), j, AW)) == target)) begin
                hit = 1'b1;
                idx = IW'(j);
            end
        end
    end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-port integer register file with write arbitration, optional
// write-to-read bypass and a per-register busy scoreboard.
module reg_file_mp
    import reg_pkg::*;
#(
    parameter int XLEN     = XLEN_DEF,
    parameter int NREGS    = NREGS_DEF,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    reg_file_mp_if.slave  bus
);

    localparam int AW = $clog2(NREGS);
    localparam int IW = (NWR > 1) ? $clog2(NWR) : 1;

    logic [XLEN-1:0]  regs [NREGS];
    logic [NREGS-1:0] busy;

    logic [AW-1:0]    waddr [NWR];
    logic [XLEN-1:0]  wdata [NWR];
    logic [NWR-1:0]   we;
    logic             alloc_ok;

    logic [NREGS-1:0] st_hit;
    logic [IW-1:0]    st_idx [NREGS];

    logic [AW-1:0]    raddr [NRD];
    logic [NRD-1:0]   byp_hit;
    logic [IW-1:0]    byp_idx [NRD];

    logic [NRD*XLEN-1:0] rd_vec;
    logic [NRD-1:0]      busy_vec;

    // Writes to r0 are removed here, so neither storage nor bypass ever sees them.
    for (genvar j = 0; j < NWR; j++) begin : g_wport
        assign waddr[j] = AW'(pack_field(PACK_MAX'(bus.rd_addr), j, AW));
        assign wdata[j] = XLEN'(pack_field(PACK_MAX'(bus.rd_data), j, XLEN));
        assign we[j]    = bus.reg_write[j] && !((ZERO_REG != 0) && (waddr[j] == '0));
    end

    assign alloc_ok = bus.alloc_valid && !((ZERO_REG != 0) && (bus.alloc_addr == '0));

    for (genvar r = 0; r < NREGS; r++) begin : g_store_arb
        rf_wr_arb #(
            .NWR (NWR),
            .AW  (AW),
            .IW  (IW)
        ) u_arb (
            .we     (we),
            .waddr  (bus.rd_addr),
            .target (AW'(r)),
            .hit    (st_hit[r]),
            .idx    (st_idx[r])
        );
    end

    // Alloc takes priority over a same-cycle write: the new producer owns the register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int r = 0; r < NREGS; r++) begin
                regs[r] <= '0;
            end
            busy <= '0;
        end else begin
            for (int r = 0; r < NREGS; r++) begin
                if (st_hit[r]) begin
                    regs[r] <= wdata[st_idx[r]];
                end
                if (alloc_ok && (bus.alloc_addr == AW'(r))) begin
                    busy[r] <= 1'b1;
                end else if (st_hit[r]) begin
                    busy[r] <= 1'b0;
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rport
        assign raddr[i] = AW'(pack_field(PACK_MAX'(bus.rs_addr), i, AW));

        rf_wr_arb #(
            .NWR (NWR),
            .AW  (AW),
            .IW  (IW)
        ) u_byp (
            .we     (we),
            .waddr  (bus.rd_addr),
            .target (raddr[i]),
            .hit    (byp_hit[i]),
            .idx    (byp_idx[i])
        );
    end

    // Busy is reported from the registered scoreboard only, never forwarded.
    always_comb begin
        rd_vec   = '0;
        busy_vec = '0;
        for (int i = 0; i < NRD; i++) begin
            if ((ZERO_REG != 0) && (raddr[i] == '0)) begin
                rd_vec[i*XLEN +: XLEN] = '0;
                busy_vec[i]            = 1'b0;
            end else begin
                if ((BYPASS != 0) && rst_n && byp_hit[i]) begin
                    rd_vec[i*XLEN +: XLEN] = wdata[byp_idx[i]];
                end else begin
                    rd_vec[i*XLEN +: XLEN] = regs[raddr[i]];
                end
                busy_vec[i] = busy[raddr[i]];
            end
        end
    end

    assign bus.rs_data  = rd_vec;
    assign bus.rs_busy  = busy_vec;
    assign bus.any_busy = |busy;

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one bypassing and one non-bypassing instance
// driven with identical stimulus.
module tb_reg_file_mp;
    import reg_pkg::*;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int NRD   = 2;
    localparam int NWR   = 2;
    localparam int AW    = AW_DEF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_fail = 0;

    reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus ();
    reg_file_mp_if #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR)) bus_nb ();

    assign bus_nb.rs_addr     = bus.rs_addr;
    assign bus_nb.reg_write   = bus.reg_write;
    assign bus_nb.rd_addr     = bus.rd_addr;
    assign bus_nb.rd_data     = bus.rd_data;
    assign bus_nb.alloc_valid = bus.alloc_valid;
    assign bus_nb.alloc_addr  = bus.alloc_addr;

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(1), .ZERO_REG(1)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWR(NWR), .BYPASS(0), .ZERO_REG(1)) u_dut_nb (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_nb)
    );

    always #5 clk = ~clk;

    function automatic logic [XLEN-1:0] dat(input int p);
        return bus.rs_data[p*XLEN +: XLEN];
    endfunction

    function automatic logic [XLEN-1:0] dat_nb(input int p);
        return bus_nb.rs_data[p*XLEN +: XLEN];
    endfunction

    task automatic clr();
        bus.reg_write   = '0;
        bus.rd_addr     = '0;
        bus.rd_data     = '0;
        bus.alloc_valid = 1'b0;
        bus.alloc_addr  = '0;
    endtask

    task automatic wr(input int p, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        bus.reg_write[p]             = 1'b1;
        bus.rd_addr[p*AW +: AW]      = a;
        bus.rd_data[p*XLEN +: XLEN]  = d;
    endtask

    task automatic rd(input int p, input logic [AW-1:0] a);
        bus.rs_addr[p*AW +: AW] = a;
    endtask

    task automatic alloc(input logic [AW-1:0] a);
        bus.alloc_valid = 1'b1;
        bus.alloc_addr  = a;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rd(0, 5'd0); rd(1, 5'd5); #1;
        n_cmp++; if (dat(0) !== 32'h0) begin n_fail++; $display("FAIL reset_r0 got %h want %h", dat(0), 32'h0); end
        n_cmp++; if (dat(1) !== 32'h0) begin n_fail++; $display("FAIL reset_r5 got %h want %h", dat(1), 32'h0); end
        n_cmp++; if (bus.any_busy !== 1'b0) begin n_fail++; $display("FAIL reset_any_busy got %b want 0", bus.any_busy); end
        n_cmp++; if (bus.rs_busy !== 2'b00) begin n_fail++; $display("FAIL reset_rs_busy got %b want 00", bus.rs_busy); end
        wr(0, 5'd5, 32'hDEADBEEF); alloc(5'd6);
        step(); clr(); #1;
        n_cmp++; if (dat(1) !== 32'hDEADBEEF) begin n_fail++; $display("FAIL preload_r5 got %h want %h", dat(1), 32'hDEADBEEF); end
        n_cmp++; if (bus.any_busy !== 1'b1) begin n_fail++; $display("FAIL preload_any_busy got %b want 1", bus.any_busy); end
        rst_n = 1'b0;
        step(); rst_n = 1'b1; #1;
        n_cmp++; if (dat(1) !== 32'h0) begin n_fail++; $display("FAIL rst_clear_r5 got %h want %h", dat(1), 32'h0); end
        n_cmp++; if (dat_nb(1) !== 32'h0) begin n_fail++; $display("FAIL rst_clear_r5_nb got %h want %h", dat_nb(1), 32'h0); end
        n_cmp++; if (bus.any_busy !== 1'b0) begin n_fail++; $display("FAIL rst_clear_any_busy got %b want 0", bus.any_busy); end
    endtask

    task automatic test_write_read();
        wr(0, 5'd3, 32'h0000000A);
        step(); clr(); rd(1, 5'd3); #1;
        n_cmp++; if (dat(1) !== 32'h0000000A) begin n_fail++; $display("FAIL wr_r3 got %h want %h", dat(1), 32'hA); end
        n_cmp++; if (dat_nb(1) !== 32'h0000000A) begin n_fail++; $display("FAIL wr_r3_nb got %h want %h", dat_nb(1), 32'hA); end
        wr(1, 5'd0, 32'h00001234); rd(0, 5'd0); #1;
        n_cmp++; if (dat(0) !== 32'h0) begin n_fail++; $display("FAIL r0_no_bypass got %h want %h", dat(0), 32'h0); end
        step(); clr(); #1;
        n_cmp++; if (dat(0) !== 32'h0) begin n_fail++; $display("FAIL r0_stored got %h want %h", dat(0), 32'h0); end
        n_cmp++; if (dat_nb(0) !== 32'h0) begin n_fail++; $display("FAIL r0_stored_nb got %h want %h", dat_nb(0), 32'h0); end
    endtask

    task automatic test_bypass();
        rd(0, 5'd7); wr(0, 5'd7, 32'h55AA55AA); #1;
        n_cmp++; if (dat(0) !== 32'h55AA55AA) begin n_fail++; $display("FAIL bypass_same_cycle got %h want %h", dat(0), 32'h55AA55AA); end
        n_cmp++; if (dat_nb(0) !== 32'h0) begin n_fail++; $display("FAIL nobypass_same_cycle got %h want %h", dat_nb(0), 32'h0); end
        step(); clr(); #1;
        n_cmp++; if (dat(0) !== 32'h55AA55AA) begin n_fail++; $display("FAIL bypass_next got %h want %h", dat(0), 32'h55AA55AA); end
        n_cmp++; if (dat_nb(0) !== 32'h55AA55AA) begin n_fail++; $display("FAIL nobypass_next got %h want %h", dat_nb(0), 32'h55AA55AA); end
    endtask

    task automatic test_conflict();
        rd(0, 5'd9); rd(1, 5'd9); wr(0, 5'd9, 32'h11); wr(1, 5'd9, 32'h22); #1;
        n_cmp++; if (dat(0) !== 32'h22) begin n_fail++; $display("FAIL conflict_bypass_p0 got %h want %h", dat(0), 32'h22); end
        n_cmp++; if (dat(1) !== 32'h22) begin n_fail++; $display("FAIL conflict_bypass_p1 got %h want %h", dat(1), 32'h22); end
        n_cmp++; if (dat_nb(0) !== 32'h0) begin n_fail++; $display("FAIL conflict_nb_old got %h want %h", dat_nb(0), 32'h0); end
        step(); clr(); #1;
        n_cmp++; if (dat(0) !== 32'h22) begin n_fail++; $display("FAIL conflict_stored got %h want %h", dat(0), 32'h22); end
        n_cmp++; if (dat_nb(0) !== 32'h22) begin n_fail++; $display("FAIL conflict_stored_nb got %h want %h", dat_nb(0), 32'h22); end
    endtask

    task automatic test_scoreboard();
        rd(0, 5'd4); rd(1, 5'd0); alloc(5'd0);
        step(); clr(); #1;
        n_cmp++; if (bus.any_busy !== 1'b0) begin n_fail++; $display("FAIL alloc_r0_any got %b want 0", bus.any_busy); end
        n_cmp++; if (bus.rs_busy[1] !== 1'b0) begin n_fail++; $display("FAIL alloc_r0_busy got %b want 0", bus.rs_busy[1]); end
        alloc(5'd4); #1;
        n_cmp++; if (bus.rs_busy[0] !== 1'b0) begin n_fail++; $display("FAIL alloc_r4_early got %b want 0", bus.rs_busy[0]); end
        step(); clr(); #1;
        n_cmp++; if (bus.rs_busy[0] !== 1'b1) begin n_fail++; $display("FAIL alloc_r4_busy got %b want 1", bus.rs_busy[0]); end
        n_cmp++; if (bus.any_busy !== 1'b1) begin n_fail++; $display("FAIL alloc_r4_any got %b want 1", bus.any_busy); end
        wr(1, 5'd4, 32'h55); #1;
        n_cmp++; if (bus.rs_busy[0] !== 1'b1) begin n_fail++; $display("FAIL busy_not_bypassed got %b want 1", bus.rs_busy[0]); end
        step(); clr(); #1;
        n_cmp++; if (bus.rs_busy[0] !== 1'b0) begin n_fail++; $display("FAIL write_clears_busy got %b want 0", bus.rs_busy[0]); end
        n_cmp++; if (bus.any_busy !== 1'b0) begin n_fail++; $display("FAIL write_clears_any got %b want 0", bus.any_busy); end
        n_cmp++; if (dat(0) !== 32'h55) begin n_fail++; $display("FAIL write_r4 got %h want %h", dat(0), 32'h55); end
        alloc(5'd4); wr(0, 5'd4, 32'h99);
        step(); clr(); #1;
        n_cmp++; if (bus.rs_busy[0] !== 1'b1) begin n_fail++; $display("FAIL alloc_wins got %b want 1", bus.rs_busy[0]); end
        n_cmp++; if (dat(0) !== 32'h99) begin n_fail++; $display("FAIL alloc_write_data got %h want %h", dat(0), 32'h99); end
        n_cmp++; if (dat_nb(0) !== 32'h99) begin n_fail++; $display("FAIL alloc_write_data_nb got %h want %h", dat_nb(0), 32'h99); end
    endtask

    task automatic test_reset_mid();
        wr(0, 5'd2, 32'h42);
        step(); clr(); rd(0, 5'd2); #1;
        n_cmp++; if (dat(0) !== 32'h42) begin n_fail++; $display("FAIL mid_pre_r2 got %h want %h", dat(0), 32'h42); end
        rst_n = 1'b0; wr(0, 5'd2, 32'hFF); alloc(5'd2); #1;
        n_cmp++; if (dat(0) !== 32'h42) begin n_fail++; $display("FAIL mid_bypass_suppressed got %h want %h", dat(0), 32'h42); end
        step(); rst_n = 1'b1; clr(); #1;
        n_cmp++; if (dat(0) !== 32'h0) begin n_fail++; $display("FAIL mid_r2_cleared got %h want %h", dat(0), 32'h0); end
        n_cmp++; if (bus.rs_busy[0] !== 1'b0) begin n_fail++; $display("FAIL mid_r2_busy got %b want 0", bus.rs_busy[0]); end
        n_cmp++; if (bus.any_busy !== 1'b0) begin n_fail++; $display("FAIL mid_any_busy got %b want 0", bus.any_busy); end
    endtask

    task automatic test_back_to_back();
        wr(0, 5'd10, 32'h1); wr(1, 5'd11, 32'h2);
        step(); clr();
        wr(0, 5'd12, 32'h3); wr(1, 5'd10, 32'h4); rd(0, 5'd10); rd(1, 5'd11); #1;
        n_cmp++; if (dat(0) !== 32'h4) begin n_fail++; $display("FAIL b2b_bypass_r10 got %h want %h", dat(0), 32'h4); end
        n_cmp++; if (dat_nb(0) !== 32'h1) begin n_fail++; $display("FAIL b2b_nb_r10 got %h want %h", dat_nb(0), 32'h1); end
        n_cmp++; if (dat(1) !== 32'h2) begin n_fail++; $display("FAIL b2b_r11 got %h want %h", dat(1), 32'h2); end
        step(); clr(); rd(1, 5'd12); #1;
        n_cmp++; if (dat(0) !== 32'h4) begin n_fail++; $display("FAIL b2b_r10_stored got %h want %h", dat(0), 32'h4); end
        n_cmp++; if (dat(1) !== 32'h3) begin n_fail++; $display("FAIL b2b_r12_stored got %h want %h", dat(1), 32'h3); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        bus.rs_addr = '0;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        test_reset();
        test_write_read();
        test_bypass();
        test_conflict();
        test_scoreboard();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
